pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/forwarding_unit.sv | 21 ++
 rtl/pipeline_hazard_controller.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types, constants and helpers for the pipeline hazard controller.
// Holds the FSM state encoding, forward-select codes and counter helpers.
package hazard_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int BOOT_CYCLES_DEF  = 2;
  localparam int DRAIN_CYCLES_DEF = 3;

  // The younger EX/MEM result takes priority over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = 16'hFFFF;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Combinational ALU operand forwarding select for both EX source operands.
module forwarding_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  // Operand source selection, independent of the controller state.
  always_comb begin
    forward_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    forward_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: boot hold, load-use stall, branch
// flush, halt drain, operand forwarding and saturating event counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_halt,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pc_src,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] BOOT_LOAD  = 2'(BOOT_CYCLES - 1);
  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES);

  state_e      state_r, state_next_s;
  logic [1:0]  cnt_r, cnt_next_s;
  logic [15:0] stall_cnt_r, flush_cnt_r;
  logic        load_use_s, stall_event_s, flush_event_s;

  assign load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  // A taken branch squashes the load-use pair, so it never counts as a stall.
  assign stall_event_s = (state_r == RUN) && load_use_s && !ex_branch_taken;
  assign flush_event_s = (state_r == RUN) && ex_branch_taken;

  // State, counter and event-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= BOOT;
      cnt_r       <= BOOT_LOAD;
      stall_cnt_r <= 16'd0;
      flush_cnt_r <= 16'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (stall_event_s) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end
      if (flush_event_s) begin
        flush_cnt_r <= sat_inc16(flush_cnt_r);
      end
    end
  end

  // Next-state and down-counter logic.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      BOOT: begin
        if (cnt_r == 2'd0) begin
          state_next_s = RUN;
        end else begin
          cnt_next_s = cnt_r - 2'd1;
        end
      end
      RUN: begin
        if (id_halt && !ex_branch_taken) begin
          state_next_s = DRAIN;
          cnt_next_s   = DRAIN_LOAD;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // Leave as the counter steps to zero so DRAIN lasts exactly DRAIN_CYCLES.
        if (cnt_r <= 2'd1) begin
          state_next_s = HALTED;
          cnt_next_s   = 2'd0;
        end else begin
          cnt_next_s = cnt_r - 2'd1;
        end
      end
      HALTED: begin
        state_next_s = HALTED;
      end
      default: begin
        state_next_s = BOOT;
        cnt_next_s   = BOOT_LOAD;
      end
    endcase
  end

  // Pipeline control outputs per state and hazard.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_src       = 1'b0;
    case (state_r)
      BOOT: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      RUN: begin
        if (ex_branch_taken) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          pc_src       = 1'b1;
        end else if (load_use_s) begin
          id_ex_bubble = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      DRAIN, HALTED: begin
        id_ex_bubble = 1'b1;
      end
      default: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    endcase
  end

  assign halted    = (state_r == HALTED);
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  forwarding_unit u_fwd (
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .forward_a     (forward_a),
    .forward_b     (forward_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed table-driven bench for pipeline_hazard_controller plus hand-written
// boot, halt, reset and counter-saturation sequences.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_halt, ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_src, halted;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_mem_read, br;
    logic [4:0] ex_rs1, ex_rs2, mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       e_pcw, e_ifw, ifw_care, e_flush, e_bub, e_src;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[12];

  pipeline_hazard_controller dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_halt(id_halt),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_src(pc_src),
    .forward_a(forward_a), .forward_b(forward_b),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_halt = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
  endtask

  task automatic load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
  endtask

  // Reset for one edge and wait out the boot hold; returns at a negedge in RUN.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    // id_rs1 id_rs2 ex_rd mr br | ex_rs1 ex_rs2 mem_rd mwe wb_rd wwe | pcw ifw care flush bub src fa fb
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[3]  = '{5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[4]  = '{5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[6]  = '{5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd7, 5'd7, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    rst = 1'b1;
    idle();

    // Boot: pc_write low for exactly two cycles after reset release.
    @(negedge clk); rst = 1'b0; #1;
    chk("boot0_pc_write", 16'(pc_write), 16'd0);
    chk("boot0_if_id_flush", 16'(if_id_flush), 16'd1);
    chk("boot0_bubble", 16'(id_ex_bubble), 16'd1);
    chk("boot0_halted", 16'(halted), 16'd0);
    chk("boot0_stall_cnt", stall_cnt, 16'd0);
    chk("boot0_flush_cnt", flush_cnt, 16'd0);
    @(negedge clk); #1;
    chk("boot1_pc_write", 16'(pc_write), 16'd0);
    @(negedge clk); #1;
    chk("run_pc_write", 16'(pc_write), 16'd1);
    chk("run_if_id_flush", 16'(if_id_flush), 16'd0);

    // Single load-use stall.
    load_use(); #1;
    chk("lu_pc_write", 16'(pc_write), 16'd0);
    chk("lu_if_id_write", 16'(if_id_write), 16'd0);
    chk("lu_bubble", 16'(id_ex_bubble), 16'd1);
    @(posedge clk); #1; idle();
    @(negedge clk); #1;
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    chk("lu_after_pc_write", 16'(pc_write), 16'd1);

    // ex_rd = x0 is never a hazard.
    load_use(); ex_rd = 5'd0; id_rs2 = 5'd0; #1;
    chk("x0_pc_write", 16'(pc_write), 16'd1);
    @(posedge clk); #1; idle();
    @(negedge clk); #1;
    chk("x0_stall_cnt", stall_cnt, 16'd1);

    // Branch beats a simultaneous load-use stall.
    load_use(); ex_branch_taken = 1'b1; #1;
    chk("bs_pc_src", 16'(pc_src), 16'd1);
    chk("bs_if_id_flush", 16'(if_id_flush), 16'd1);
    chk("bs_pc_write", 16'(pc_write), 16'd1);
    chk("bs_bubble", 16'(id_ex_bubble), 16'd1);
    @(posedge clk); #1; idle();
    @(negedge clk); #1;
    chk("bs_flush_cnt", flush_cnt, 16'd1);
    chk("bs_stall_cnt", stall_cnt, 16'd1);

    // Table of single-cycle RUN vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].id_rs1; id_rs2 = vecs[i].id_rs2; ex_rd = vecs[i].ex_rd;
      ex_mem_read = vecs[i].ex_mem_read; ex_branch_taken = vecs[i].br;
      ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_we;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_we;
      #1;
      chk($sformatf("v%0d_pc_write", i), 16'(pc_write), 16'(vecs[i].e_pcw));
      if (vecs[i].ifw_care) begin
        chk($sformatf("v%0d_if_id_write", i), 16'(if_id_write), 16'(vecs[i].e_ifw));
      end
      chk($sformatf("v%0d_if_id_flush", i), 16'(if_id_flush), 16'(vecs[i].e_flush));
      chk($sformatf("v%0d_bubble", i), 16'(id_ex_bubble), 16'(vecs[i].e_bub));
      chk($sformatf("v%0d_pc_src", i), 16'(pc_src), 16'(vecs[i].e_src));
      chk($sformatf("v%0d_forward_a", i), 16'(forward_a), 16'(vecs[i].e_fa));
      chk($sformatf("v%0d_forward_b", i), 16'(forward_b), 16'(vecs[i].e_fb));
    end
    @(posedge clk); #1; idle();
    @(negedge clk); #1;
    chk("tbl_stall_cnt", stall_cnt, 16'd3);
    chk("tbl_flush_cnt", flush_cnt, 16'd3);

    // Halt: three DRAIN cycles then HALTED, forwarding still live.
    id_halt = 1'b1; #1;
    chk("halt_req_pc_write", 16'(pc_write), 16'd1);
    @(posedge clk); #1; idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("drain%0d_pc_write", i), 16'(pc_write), 16'd0);
      chk($sformatf("drain%0d_halted", i), 16'(halted), 16'd0);
      chk($sformatf("drain%0d_bubble", i), 16'(id_ex_bubble), 16'd1);
    end
    @(negedge clk); #1;
    chk("halted", 16'(halted), 16'd1);
    chk("halted_pc_write", 16'(pc_write), 16'd0);
    ex_branch_taken = 1'b1; ex_rs2 = 5'd8; wb_rd = 5'd8; wb_reg_write = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("halted_sticky", 16'(halted), 16'd1);
    chk("halted_pc_src", 16'(pc_src), 16'd0);
    chk("halted_forward_b", 16'(forward_b), 16'd1);
    idle();

    // Reset mid-DRAIN returns to BOOT at the next edge.
    do_reset();
    id_halt = 1'b1;
    @(posedge clk); #1; idle();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_drain_halted", 16'(halted), 16'd0);
    chk("rst_drain_pc_write", 16'(pc_write), 16'd0);
    chk("rst_drain_if_id_flush", 16'(if_id_flush), 16'd1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_drain_reboot", 16'(pc_write), 16'd1);

    // Reset wins over a stall in the same cycle.
    load_use(); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; idle();
    @(negedge clk); #1;
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_stall_pc_write", 16'(pc_write), 16'd0);
    @(negedge clk);
    @(negedge clk); #1;

    // Saturation of stall_cnt.
    load_use();
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", stall_cnt, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_pc_write", 16'(pc_write), 16'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
